cm_vshr: RTL

Parametrised shift-register delay line with a per-stage valid qualifier, clock-enable (stall), synchronous flush and run-time selectable output tap. It generalises the fixed-length cm_shr delay line for datapaths that need variable latency alignment and stall-aware pipelining. It sits between producer/consumer stages in lib_cm users and reports pipeline occupancy.

---
 rtl/cm_pkg.sv | 20 ++
 rtl/cm_vshr_if.sv | 36 +++
 rtl/cm_vshr_ctl.sv | 55 +++++
 rtl/cm_vshr.sv | 75 +++++++
 4 files changed

// File: rtl/cm_pkg.sv
// +---------------------------------------------------------------------------+
// | cm_pkg : shared types and helpers for the cm_* delay-line family          |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package cm_pkg;

   typedef enum logic [0:0] {
      SHR_RST_FIRST = 1'b0,
      SHR_RST_FULL  = 1'b1
   } t_shr_rst;

   function automatic int unsigned f_clamp_sel(input int unsigned sel, input int unsigned len);
      return (sel > len) ? len : sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cm_vshr_if.sv
// +---------------------------------------------------------------------------+
// | cm_vshr_if : stream/tap bundle of the variable delay line                 |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface cm_vshr_if #(
   parameter int  LEN   = 4,
   parameter type DTYPE = logic [7:0]
);
   localparam int SW = $clog2(LEN + 1);

   logic                 i_en;
   logic                 i_flush;
   logic                 i_vld;
   DTYPE                 i_data;
   logic [SW-1:0]        i_sel;
   logic                 o_vld;
   DTYPE                 o_data;
   logic [LEN-1:0]       o_tap_vld;
   DTYPE [LEN-1:0]       o_taps;
   logic [SW-1:0]        o_cnt;

   modport master (
      output i_en, i_flush, i_vld, i_data, i_sel,
      input  o_vld, o_data, o_tap_vld, o_taps, o_cnt
   );

   modport slave (
      input  i_en, i_flush, i_vld, i_data, i_sel,
      output o_vld, o_data, o_tap_vld, o_taps, o_cnt
   );

endinterface

`default_nettype wire

// File: rtl/cm_vshr_ctl.sv
// +---------------------------------------------------------------------------+
// | cm_vshr_ctl : valid-bit chain with reset/flush priority and occupancy     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module cm_vshr_ctl #(
   parameter  int LEN = 4,
   localparam int SW  = $clog2(LEN + 1)
) (
   input  wire logic           i_clk,
   input  wire logic           i_rst,
   input  wire logic           i_en,
   input  wire logic           i_flush,
   input  wire logic           i_vld,
   output logic [LEN-1:0]      vld_o,
   output logic [SW-1:0]       cnt_o
);

   logic [LEN-1:0] vld_q, vld_d;
   logic [SW-1:0]  cnt_q, cnt_d;

   // Count tracks entry at stage 0 and exit past the last stage, so it
   // always equals the number of set valid bits without a popcount tree.
   always_comb begin
      vld_d    = vld_q;
      cnt_d    = cnt_q;
      if (i_en) begin
         vld_d[0] = i_vld;
         for (int k = 1; k < LEN; k++) begin
            vld_d[k] = vld_q[k-1];
         end
         cnt_d = cnt_q + SW'(i_vld) - SW'(vld_q[LEN-1]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign vld_o = vld_q;
   assign cnt_o = cnt_q;

   a_cnt_pop : assert property (@(posedge i_clk) disable iff (i_rst)
      cnt_q == SW'($countones(vld_q)));

endmodule

`default_nettype wire

// File: rtl/cm_vshr.sv
// +---------------------------------------------------------------------------+
// | cm_vshr : stall-aware variable-tap delay line with per-stage valid        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module cm_vshr
   import cm_pkg::*;
#(
   parameter int       LEN      = 4,
   parameter type      DTYPE    = logic [7:0],
   parameter t_shr_rst RST_MODE = SHR_RST_FIRST,
   localparam int      SW       = $clog2(LEN + 1)
) (
   input  wire logic   i_clk,
   input  wire logic   i_rst,
   cm_vshr_if.slave    bus
);

   generate
      if (LEN < 1 || LEN > 255) begin : g_len_err
         $error("cm_vshr: LEN must be in 1..255");
      end
   endgenerate

   DTYPE [LEN-1:0] data_q;
   logic [LEN-1:0] vld_w;
   logic [SW-1:0]  sel_c;

   cm_vshr_ctl #(.LEN(LEN)) u_ctl (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (bus.i_en),
      .i_flush (bus.i_flush),
      .i_vld   (bus.i_vld),
      .vld_o   (vld_w),
      .cnt_o   (bus.o_cnt)
   );

   // Flush never touches payload; only reset clears it, and only stage 0
   // unless the full-clear variant is selected.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q[0] <= '0;
      end else if (bus.i_en) begin
         data_q[0] <= bus.i_data;
      end
      for (int k = 1; k < LEN; k++) begin
         if (i_rst && (RST_MODE == SHR_RST_FULL)) begin
            data_q[k] <= '0;
         end else if (bus.i_en) begin
            data_q[k] <= data_q[k-1];
         end
      end
   end

   assign sel_c = SW'(f_clamp_sel(32'(bus.i_sel), LEN));

   always_comb begin
      bus.o_data = bus.i_data;
      bus.o_vld  = bus.i_vld;
      for (int k = 1; k <= LEN; k++) begin
         if (sel_c == SW'(k)) begin
            bus.o_data = data_q[k-1];
            bus.o_vld  = vld_w[k-1];
         end
      end
   end

   assign bus.o_tap_vld = vld_w;
   assign bus.o_taps    = data_q;

endmodule

`default_nettype wire
